// File: rtl/fib_checker.sv
// fib_checker: consumes a stream of WIDTH-bit terms over valid/ready and
// checks that every term after the two seeds is the modulo-2^WIDTH sum of
// the two terms before it. The first mismatch is captured and the block
// stalls (in_ready low) until clr or rst.
module fib_checker #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] seed0,
  output logic [WIDTH-1:0] seed1,
  output logic [CNT_W-1:0] term_cnt,
  output logic             ok,
  output logic             err,
  output logic [CNT_W-1:0] err_idx,
  output logic [WIDTH-1:0] err_exp,
  output logic [WIDTH-1:0] err_got
);

  typedef enum logic [1:0] {
    SEED0 = 2'd0,
    SEED1 = 2'd1,
    CHECK = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [WIDTH-1:0] r0;
  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] expSum;
  logic [CNT_W-1:0] nextCnt;
  logic             accept;
  logic             termMatch;

  // Ready is a pure state decode so the producer never sees a loop through in_valid.
  assign in_ready = (state != ERR);

  assign accept = in_valid & in_ready;

  // The carry out of the adder is dropped, giving the modulo-2^WIDTH sum.
  assign expSum = r0 + r1;

  assign termMatch = (in_data == expSum);

  // Term counter advance that sticks at all-ones rather than wrapping.
  always_comb begin
    nextCnt = term_cnt;
    if (term_cnt != CNT_MAX) begin
      nextCnt = term_cnt + CNT_ONE;
    end
  end

  // Checker state machine with every status output registered alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SEED0;
      r0       <= '0;
      r1       <= '0;
      seed0    <= '0;
      seed1    <= '0;
      term_cnt <= '0;
      ok       <= 1'b0;
      err      <= 1'b0;
      err_idx  <= '0;
      err_exp  <= '0;
      err_got  <= '0;
    end else begin
      ok <= 1'b0;
      if (clr) begin
        state    <= SEED0;
        r0       <= '0;
        r1       <= '0;
        seed0    <= '0;
        seed1    <= '0;
        term_cnt <= '0;
        err      <= 1'b0;
        err_idx  <= '0;
        err_exp  <= '0;
        err_got  <= '0;
      end else if (accept) begin
        term_cnt <= nextCnt;
        unique case (state)
          SEED0: begin
            seed0 <= in_data;
            r0    <= in_data;
            state <= SEED1;
          end
          SEED1: begin
            seed1 <= in_data;
            r1    <= in_data;
            state <= CHECK;
          end
          CHECK: begin
            if (termMatch) begin
              r0 <= r1;
              r1 <= in_data;
              ok <= 1'b1;
            end else begin
              err     <= 1'b1;
              err_idx <= term_cnt;
              err_exp <= expSum;
              err_got <= in_data;
              state   <= ERR;
            end
          end
          default: begin
            state <= ERR;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fib_checker.sv
// tb_fib_checker: table-driven and randomized self-check of fib_checker
// against a term-history reference model, plus a CNT_W=4 instance for
// counter saturation.
module tb_fib_checker;

  localparam int WIDTH = 6;
  localparam int MOD   = 64;
  localparam int CMAX  = 255;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       in_valid;
  logic [5:0] in_data;
  logic       in_ready;
  logic [5:0] seed0;
  logic [5:0] seed1;
  logic [7:0] term_cnt;
  logic       ok;
  logic       err;
  logic [7:0] err_idx;
  logic [5:0] err_exp;
  logic [5:0] err_got;

  logic       satClr;
  logic       satValid;
  logic [5:0] satData;
  logic       satReady;
  logic [5:0] satSeed0;
  logic [5:0] satSeed1;
  logic [3:0] satCnt;
  logic       satOk;
  logic       satErr;
  logic [3:0] satIdx;
  logic [5:0] satExp;
  logic [5:0] satGot;

  int checks;
  int failures;
  int okSeen;

  int  hist[$];
  bit  mErr;
  bit  mOk;
  int  mCnt;
  int  mSeed0;
  int  mSeed1;
  int  mIdx;
  int  mExp;
  int  mGot;

  typedef struct {
    int d;
    bit expOk;
    int expCnt;
  } vec_t;

  fib_checker #(.WIDTH(WIDTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .seed0(seed0), .seed1(seed1), .term_cnt(term_cnt),
    .ok(ok), .err(err), .err_idx(err_idx), .err_exp(err_exp), .err_got(err_got)
  );

  fib_checker #(.WIDTH(WIDTH), .CNT_W(4)) dutSat (
    .clk(clk), .rst(rst), .clr(satClr), .in_valid(satValid), .in_data(satData),
    .in_ready(satReady), .seed0(satSeed0), .seed1(satSeed1), .term_cnt(satCnt),
    .ok(satOk), .err(satErr), .err_idx(satIdx), .err_exp(satExp), .err_got(satGot)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void checkVal(string name, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, got, want, $time);
    end
  endfunction

  function automatic void resetModel();
    hist.delete();
    mErr = 0; mOk = 0; mCnt = 0;
    mSeed0 = 0; mSeed1 = 0; mIdx = 0; mExp = 0; mGot = 0;
  endfunction

  function automatic int modelNext();
    int n;
    n = hist.size();
    if (n < 2) return 0;
    return (hist[n-1] + hist[n-2]) % MOD;
  endfunction

  // One clock edge of the reference: the term history decides what is a seed
  // and what must be the sum of the last two accepted terms.
  function automatic void modelStep(bit c, bit v, int d);
    int e;
    mOk = 0;
    if (c) begin
      resetModel();
    end else if (v && !mErr) begin
      if (hist.size() == 0) begin
        mSeed0 = d;
        hist.push_back(d);
      end else if (hist.size() == 1) begin
        mSeed1 = d;
        hist.push_back(d);
      end else begin
        e = modelNext();
        if (d == e) begin
          hist.push_back(d);
          mOk = 1;
        end else begin
          mErr = 1; mIdx = mCnt; mExp = e; mGot = d;
        end
      end
      mCnt = (mCnt < CMAX) ? mCnt + 1 : CMAX;
    end
  endfunction

  task automatic checkOutput(string tag);
    checkVal({tag, ".in_ready"}, int'(in_ready), mErr ? 0 : 1);
    checkVal({tag, ".seed0"},    int'(seed0),    mSeed0);
    checkVal({tag, ".seed1"},    int'(seed1),    mSeed1);
    checkVal({tag, ".term_cnt"}, int'(term_cnt), mCnt);
    checkVal({tag, ".ok"},       int'(ok),       int'(mOk));
    checkVal({tag, ".err"},      int'(err),      int'(mErr));
    checkVal({tag, ".err_idx"},  int'(err_idx),  mIdx);
    checkVal({tag, ".err_exp"},  int'(err_exp),  mExp);
    checkVal({tag, ".err_got"},  int'(err_got),  mGot);
  endtask

  task automatic applyStimulus(string tag, bit c, bit v, int d);
    clr      = c;
    in_valid = v;
    in_data  = 6'(d);
    @(posedge clk);
    modelStep(c, v, d);
    #1;
    if (ok) okSeen++;
    checkOutput(tag);
  endtask

  task automatic streamTerms(string tag, int terms[$]);
    foreach (terms[i]) applyStimulus(tag, 1'b0, 1'b1, terms[i]);
    in_valid = 1'b0;
  endtask

  initial begin
    vec_t nominal[12];
    int   wrapTerms[12];
    int   satOkSeen;
    bit   c;
    bit   v;
    int   d;

    checks = 0; failures = 0; okSeen = 0;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    satClr = 1'b0; satValid = 1'b0; satData = '0;
    resetModel();

    #12;
    checkOutput("reset");
    checkVal("reset.satCnt", int'(satCnt), 0);
    checkVal("reset.satReady", int'(satReady), 1);
    @(negedge clk);
    rst = 1'b0;

    wrapTerms = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 25, 16};
    for (int i = 0; i < 12; i++) begin
      nominal[i].d      = wrapTerms[i];
      nominal[i].expOk  = (i >= 2);
      nominal[i].expCnt = i + 1;
    end

    // Nominal stream through the 2^WIDTH wrap point.
    okSeen = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus("wrap", 1'b0, 1'b1, nominal[i].d);
      checkVal("wrap.tableOk", int'(ok), int'(nominal[i].expOk));
      checkVal("wrap.tableCnt", int'(term_cnt), nominal[i].expCnt);
    end
    in_valid = 1'b0;
    checkVal("wrap.okCount", okSeen, 10);
    checkVal("wrap.seed0", int'(seed0), 1);
    checkVal("wrap.seed1", int'(seed1), 1);
    checkVal("wrap.err", int'(err), 0);
    checkVal("wrap.cnt", int'(term_cnt), 12);

    // Mismatch on the fourth term, then stall.
    applyStimulus("clr0", 1'b1, 1'b0, 0);
    streamTerms("mis", '{1, 1, 2, 4, 7});
    applyStimulus("misHold", 1'b0, 1'b1, 7);
    in_valid = 1'b0;
    checkVal("mis.err", int'(err), 1);
    checkVal("mis.idx", int'(err_idx), 3);
    checkVal("mis.exp", int'(err_exp), 3);
    checkVal("mis.got", int'(err_got), 4);
    checkVal("mis.ready", int'(in_ready), 0);
    checkVal("mis.cnt", int'(term_cnt), 4);

    // Clear wins over a same-cycle valid term.
    applyStimulus("clrValid", 1'b1, 1'b1, 9);
    checkVal("clrValid.cnt", int'(term_cnt), 0);
    checkVal("clrValid.err", int'(err), 0);
    checkVal("clrValid.ready", int'(in_ready), 1);
    checkVal("clrValid.seed0", int'(seed0), 0);
    okSeen = 0;
    streamTerms("afterClr", '{2, 3, 5});
    checkVal("afterClr.seed0", int'(seed0), 2);
    checkVal("afterClr.seed1", int'(seed1), 3);
    checkVal("afterClr.okCount", okSeen, 1);

    // Gapped handshake with three idle cycles between terms.
    applyStimulus("clr1", 1'b1, 1'b0, 0);
    okSeen = 0;
    foreach (wrapTerms[i]) begin
      if (i < 4) begin
        applyStimulus("gap", 1'b0, 1'b1, (i == 0) ? 0 : ((i == 3) ? 2 : 1));
        for (int g = 0; g < 3; g++) begin
          applyStimulus("gapIdle", 1'b0, 1'b0, $urandom_range(0, 63));
          checkVal("gapIdle.ok", int'(ok), 0);
        end
      end
    end
    checkVal("gap.okCount", okSeen, 2);
    checkVal("gap.err", int'(err), 0);

    // Asynchronous reset between clock edges.
    applyStimulus("clr2", 1'b1, 1'b0, 0);
    streamTerms("pre", '{1, 2, 3, 5, 8});
    #2;
    rst = 1'b1;
    #1;
    resetModel();
    checkOutput("asyncRst");
    #1;
    rst = 1'b0;
    okSeen = 0;
    streamTerms("postRst", '{5, 5, 10});
    checkVal("postRst.seed0", int'(seed0), 5);
    checkVal("postRst.seed1", int'(seed1), 5);
    checkVal("postRst.okCount", okSeen, 1);

    // Randomized traffic: mostly correct continuations, occasional corruption and clears.
    applyStimulus("clr3", 1'b1, 1'b0, 0);
    for (int i = 0; i < 600; i++) begin
      c = ($urandom_range(0, 59) == 0) || (mErr && $urandom_range(0, 5) == 0);
      v = ($urandom_range(0, 3) != 0);
      if (hist.size() >= 2 && $urandom_range(0, 9) != 0) d = modelNext();
      else d = $urandom_range(0, 63);
      applyStimulus("rand", c, v, d);
    end
    clr = 1'b0;
    in_valid = 1'b0;

    // Saturation on the narrow-counter instance with an all-zero stream.
    satOkSeen = 0;
    for (int i = 1; i <= 20; i++) begin
      satValid = 1'b1;
      satData  = '0;
      @(posedge clk);
      #1;
      if (satOk) satOkSeen++;
      checkVal("sat.cnt", int'(satCnt), (i < 15) ? i : 15);
    end
    satValid = 1'b0;
    checkVal("sat.finalCnt", int'(satCnt), 15);
    checkVal("sat.okCount", satOkSeen, 18);
    checkVal("sat.err", int'(satErr), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
